// File: rtl/trap_epc_stack.sv
// trap_epc_stack: LIFO of {exception PC, cause} entries for nested traps.
// A push stores the trapping PC, a return pops it, and a trap raised by the
// return instruction itself replaces the top entry. Refused pushes and pops
// raise sticky error flags, which clr_err clears.

`ifndef INSTRUCTION_DEPTH
`define INSTRUCTION_DEPTH 256
`endif

module trap_epc_stack #(
  parameter int PC_WIDTH    = $clog2(`INSTRUCTION_DEPTH),
  parameter int CAUSE_WIDTH = 4,
  parameter int DEPTH       = 4,
  parameter int LW          = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   trap_en,
  input  logic [PC_WIDTH-1:0]    trap_pc,
  input  logic [CAUSE_WIDTH-1:0] trap_cause,
  input  logic                   ret_en,
  input  logic                   clr_err,
  output logic [PC_WIDTH-1:0]    top_pc,
  output logic [CAUSE_WIDTH-1:0] top_cause,
  output logic [LW-1:0]          level,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int EW = PC_WIDTH + CAUSE_WIDTH;

  // Resolved stack operation for the current cycle.
  typedef enum logic [2:0] {
    OP_IDLE      = 3'd0,
    OP_PUSH      = 3'd1,
    OP_POP       = 3'd2,
    OP_REPLACE   = 3'd3,
    OP_OVERFLOW  = 3'd4,
    OP_UNDERFLOW = 3'd5
  } op_e;

  logic [EW-1:0] entry_r [DEPTH];
  logic [LW-1:0] level_r;
  logic          overflow_r;
  logic          underflow_r;

  op_e           op_s;
  logic          empty_s;
  logic          full_s;
  logic [LW-1:0] level_nxt_s;
  logic          wr_en_s;
  logic [LW-1:0] wr_idx_s;
  logic [EW-1:0] wr_data_s;
  logic          set_ovf_s;
  logic          set_udf_s;
  logic [LW-1:0] top_idx_s;
  logic [EW-1:0] top_entry_s;

  assign empty_s   = (level_r == LW'(0));
  assign full_s    = (level_r == LW'(DEPTH));
  assign wr_data_s = {trap_pc, trap_cause};

  // Classify the request pair against the current fill level.
  // A trap on the return itself replaces the top entry; on an empty stack
  // there is nothing to replace, so it degenerates to a plain push (DEPTH>=2
  // guarantees an empty stack is never full).
  always_comb begin
    op_s = OP_IDLE;
    case ({trap_en, ret_en})
      2'b10: begin
        if (full_s) begin
          op_s = OP_OVERFLOW;
        end else begin
          op_s = OP_PUSH;
        end
      end
      2'b01: begin
        if (empty_s) begin
          op_s = OP_UNDERFLOW;
        end else begin
          op_s = OP_POP;
        end
      end
      2'b11: begin
        if (empty_s) begin
          op_s = OP_PUSH;
        end else begin
          op_s = OP_REPLACE;
        end
      end
      default: op_s = OP_IDLE;
    endcase
  end

  // Derive write strobe, write index, next level and error events.
  // A pop only moves the level; the vacated entry keeps its old contents.
  always_comb begin
    level_nxt_s = level_r;
    wr_en_s     = 1'b0;
    wr_idx_s    = level_r;
    set_ovf_s   = 1'b0;
    set_udf_s   = 1'b0;
    case (op_s)
      OP_PUSH: begin
        wr_en_s     = 1'b1;
        wr_idx_s    = level_r;
        level_nxt_s = level_r + LW'(1);
      end
      OP_REPLACE: begin
        wr_en_s  = 1'b1;
        wr_idx_s = level_r - LW'(1);
      end
      OP_POP: begin
        level_nxt_s = level_r - LW'(1);
      end
      OP_OVERFLOW: begin
        set_ovf_s = 1'b1;
      end
      OP_UNDERFLOW: begin
        set_udf_s = 1'b1;
      end
      default: begin
        level_nxt_s = level_r;
      end
    endcase
  end

  // Level counter and sticky error flags; a new error beats clr_err.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      level_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      level_r     <= level_nxt_s;
      overflow_r  <= set_ovf_s | (overflow_r & ~clr_err);
      underflow_r <= set_udf_s | (underflow_r & ~clr_err);
    end
  end

  // Entry storage; only the addressed entry is written on push/replace.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rstn) begin
        entry_r[i] <= '0;
      end else if (wr_en_s && (wr_idx_s == LW'(i))) begin
        entry_r[i] <= wr_data_s;
      end
    end
  end

  // Select the top entry (index level-1) from registered state; 0 when empty.
  always_comb begin
    top_idx_s   = level_r - LW'(1);
    top_entry_s = '0;
    if (!empty_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        top_entry_s = (top_idx_s == LW'(i)) ? entry_r[i] : top_entry_s;
      end
    end else begin
      top_entry_s = '0;
    end
  end

  assign top_pc    = top_entry_s[EW-1:CAUSE_WIDTH];
  assign top_cause = top_entry_s[CAUSE_WIDTH-1:0];
  assign level     = level_r;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_trap_epc_stack.sv
// Self-checking bench for trap_epc_stack (DEPTH=4, 8-bit PC, 4-bit cause).
// Expected states are pushed to a scoreboard queue as each cycle is driven
// and popped for comparison once the DUT has taken the edge.

module tb_trap_epc_stack;

  localparam int PCW = 8;
  localparam int CW  = 4;
  localparam int D   = 4;
  localparam int LW  = 3;

  logic           clk = 1'b0;
  logic           rstn;
  logic           trap_en;
  logic [PCW-1:0] trap_pc;
  logic [CW-1:0]  trap_cause;
  logic           ret_en;
  logic           clr_err;
  logic [PCW-1:0] top_pc;
  logic [CW-1:0]  top_cause;
  logic [LW-1:0]  level;
  logic           empty;
  logic           full;
  logic           overflow;
  logic           underflow;

  typedef struct packed {
    logic [LW-1:0]  lv;
    logic [PCW-1:0] pc;
    logic [CW-1:0]  cs;
    logic           emp;
    logic           ful;
    logic           ovf;
    logic           udf;
  } st_t;

  st_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  trap_epc_stack #(
    .PC_WIDTH   (PCW),
    .CAUSE_WIDTH(CW),
    .DEPTH      (D)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .trap_en   (trap_en),
    .trap_pc   (trap_pc),
    .trap_cause(trap_cause),
    .ret_en    (ret_en),
    .clr_err   (clr_err),
    .top_pc    (top_pc),
    .top_cause (top_cause),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  function automatic st_t obs();
    st_t r;
    r.lv  = level;
    r.pc  = top_pc;
    r.cs  = top_cause;
    r.emp = empty;
    r.ful = full;
    r.ovf = overflow;
    r.udf = underflow;
    return r;
  endfunction

  function automatic st_t mk(input int lv, input int pc, input int cs,
                             input logic emp, input logic ful,
                             input logic ovf, input logic udf);
    st_t r;
    r.lv  = LW'(lv);
    r.pc  = PCW'(pc);
    r.cs  = CW'(cs);
    r.emp = emp;
    r.ful = ful;
    r.ovf = ovf;
    r.udf = udf;
    return r;
  endfunction

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic step(input logic t, input int pc, input int cs,
                      input logic r, input logic clr, input logic rn);
    trap_en    = t;
    trap_pc    = PCW'(pc);
    trap_cause = CW'(cs);
    ret_en     = r;
    clr_err    = clr;
    rstn       = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    st_t got, e;
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
      got = obs();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset[%0d] got %p want %p", i, got, e);
      end
    end
  endtask

  task automatic test_nesting();
    st_t got, e;
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        step(1'b1, 16 * (i + 1), i + 1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(mk(i + 1, 16 * (i + 1), i + 1, 1'b0, 1'b0, 1'b0, 1'b0));
      end else begin
        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        if (i == 5) begin
          exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        end else begin
          exp_q.push_back(mk(5 - i, 16 * (5 - i), 5 - i, 1'b0, 1'b0, 1'b0, 1'b0));
        end
      end
      got = obs();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL nesting[%0d] got %p want %p", i, got, e);
      end
    end
  endtask

  task automatic test_overflow();
    st_t got, e;
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      if (k <= 5) begin
        step(1'b1, 16 * k, k, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(mk((k < 4) ? k : 4, (k <= 4) ? 16 * k : 8'h40,
                           (k <= 4) ? k : 4, 1'b0, (k >= 4), (k == 5), 1'b0));
      end else begin
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(mk(4, 8'h40, 4, 1'b0, 1'b1, 1'b0, 1'b0));
      end
      got = obs();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL overflow[%0d] got %p want %p", k, got, e);
      end
    end
  endtask

  task automatic test_underflow();
    st_t got, e;
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          step(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
          exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1));
        end
        1: begin
          step(1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
          exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1));
        end
        default: begin
          step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
          exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
      endcase
      got = obs();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL underflow[%0d] got %p want %p", i, got, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    st_t got, e;
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin
          step(1'b1, 8'h10, 1, 1'b0, 1'b0, 1'b1);
          exp_q.push_back(mk(1, 8'h10, 1, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        1: begin
          step(1'b1, 8'h20, 2, 1'b0, 1'b0, 1'b1);
          exp_q.push_back(mk(2, 8'h20, 2, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        2: begin
          step(1'b1, 8'h99, 7, 1'b1, 1'b0, 1'b1);
          exp_q.push_back(mk(2, 8'h99, 7, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        3: begin
          step(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
          exp_q.push_back(mk(1, 8'h10, 1, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        4: begin
          step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
          exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        default: begin
          step(1'b1, 8'h99, 7, 1'b1, 1'b0, 1'b1);
          exp_q.push_back(mk(1, 8'h99, 7, 1'b0, 1'b0, 1'b0, 1'b0));
        end
      endcase
      got = obs();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL simultaneous[%0d] got %p want %p", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    st_t got, e;
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h50 + i, 8 + i, 1'b0, 1'b0, 1'b1);
    end
    exp_q.push_back(mk(3, 8'h52, 10, 1'b0, 1'b0, 1'b0, 1'b0));
    got = obs();
    e   = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_mid_pre got %p want %p", got, e);
    end
    step(1'b1, 8'h77, 5, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL reset_mid[%0d] got %p want %p", i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    st_t got, e;
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin
          step(1'b1, 8'h11, 1, 1'b0, 1'b0, 1'b1);
          exp_q.push_back(mk(1, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        1: begin
          step(1'b1, 8'h22, 2, 1'b0, 1'b0, 1'b1);
          exp_q.push_back(mk(2, 8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        2: begin
          step(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
          exp_q.push_back(mk(1, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        3: begin
          step(1'b1, 8'h33, 3, 1'b0, 1'b0, 1'b1);
          exp_q.push_back(mk(2, 8'h33, 3, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        4: begin
          step(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
          exp_q.push_back(mk(1, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        default: begin
          step(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
          exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
      endcase
      got = obs();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %p want %p", i, got, e);
      end
    end
  endtask

  initial begin
    rstn       = 1'b0;
    trap_en    = 1'b0;
    trap_pc    = '0;
    trap_cause = '0;
    ret_en     = 1'b0;
    clr_err    = 1'b0;
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_nesting();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
